// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: in-order bus requests, redirect handling with
// response discard, and a FQ_DEPTH-entry fetch queue presented to decode.
module if_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic            wb_exp_int_flag,
  input  logic [XLEN-1:0] meh_addr,
  input  logic            id_is_mret_inst,
  input  logic [XLEN-1:0] mret_addr,
  input  logic            bj_flag,
  input  logic [XLEN-1:0] bj_addr,
  input  logic            pipe_stall,
  output logic            ibus_req,
  output logic [XLEN-1:0] ibus_addr,
  input  logic            ibus_gnt,
  input  logic            ibus_rvalid,
  input  logic [XLEN-1:0] ibus_rdata,
  input  logic            ibus_err,
  output logic            if_inst_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic            if_inst_addr_misal,
  output logic            if_bus_err
);

  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            misal;
    logic            err;
  } fq_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  fq_entry_t       fq_mem [FQ_DEPTH];
  logic [PTR_W-1:0] fq_wr_q, fq_rd_q;
  logic [CNT_W-1:0] fq_cnt_q;

  // PCs of granted, not-yet-returned, non-discarded requests in issue order
  logic [XLEN-1:0]  trk_mem [FQ_DEPTH];
  logic [PTR_W-1:0] trk_wr_q, trk_rd_q;

  logic [CNT_W-1:0] osd_cnt_q, osd_cnt_d;
  logic [CNT_W-1:0] dis_cnt_q, dis_cnt_d;

  logic            redirect;
  logic [XLEN-1:0] redirect_addr;
  logic            pc_aligned;
  logic            has_room;
  logic            fq_full;
  logic            grant;
  logic            rsp_any;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            misal_push;
  logic            push;
  logic            pop;
  fq_entry_t       push_entry;

  // Request, queue-control and next-state decode
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    osd_cnt_d     = osd_cnt_q;
    dis_cnt_d     = dis_cnt_q;
    redirect      = wb_exp_int_flag | id_is_mret_inst | bj_flag;
    redirect_addr = bj_addr;
    push_entry    = '0;
    push          = 1'b0;

    if (wb_exp_int_flag) begin
      redirect_addr = meh_addr;
    end else if (id_is_mret_inst) begin
      redirect_addr = mret_addr;
    end

    pc_aligned = (pc_q[1:0] == 2'b00);
    fq_full    = (fq_cnt_q == CNT_W'(FQ_DEPTH));
    has_room   = (({1'b0, fq_cnt_q} + {1'b0, osd_cnt_q}) < SUM_W'(FQ_DEPTH));
    ibus_req   = !rst && (state_q == RUN) && if_valid && pc_aligned && has_room;
    ibus_addr  = pc_q;
    grant      = ibus_req && ibus_gnt;

    rsp_any  = ibus_rvalid && (osd_cnt_q != '0);
    rsp_keep = rsp_any && (dis_cnt_q == '0);
    rsp_drop = rsp_any && (dis_cnt_q != '0);

    // A misaligned PC only becomes an entry once nothing older can still land
    misal_push = !rst && (state_q == RUN) && if_valid && !pc_aligned && !fq_full &&
                 (osd_cnt_q == dis_cnt_q) && !rsp_keep && !redirect;

    if (rsp_keep && !fq_full) begin
      push       = !redirect;
      push_entry = '{pc: trk_mem[trk_rd_q], inst: ibus_rdata, misal: 1'b0, err: ibus_err};
    end else if (misal_push) begin
      push       = 1'b1;
      push_entry = '{pc: pc_q, inst: '0, misal: 1'b1, err: 1'b0};
    end

    pop = (fq_cnt_q != '0) && !pipe_stall && !redirect;

    osd_cnt_d = osd_cnt_q + CNT_W'(grant) - CNT_W'(rsp_any);

    if (redirect) begin
      state_d   = RUN;
      pc_d      = redirect_addr;
      dis_cnt_d = osd_cnt_d;
    end else begin
      if (grant) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (misal_push || (rsp_keep && ibus_err)) begin
        state_d = HALT;
      end
      if (rsp_drop) begin
        dis_cnt_d = dis_cnt_q - CNT_W'(1);
      end
    end
  end

  // State, counters, request tracker and fetch queue storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      osd_cnt_q <= '0;
      dis_cnt_q <= '0;
      fq_wr_q   <= '0;
      fq_rd_q   <= '0;
      fq_cnt_q  <= '0;
      trk_wr_q  <= '0;
      trk_rd_q  <= '0;
      fq_mem    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      osd_cnt_q <= osd_cnt_d;
      dis_cnt_q <= dis_cnt_d;
      if (redirect) begin
        fq_wr_q  <= '0;
        fq_rd_q  <= '0;
        fq_cnt_q <= '0;
        trk_wr_q <= '0;
        trk_rd_q <= '0;
      end else begin
        if (push) begin
          fq_mem[fq_wr_q] <= push_entry;
          fq_wr_q         <= fq_wr_q + PTR_W'(1);
        end
        if (pop) begin
          fq_rd_q <= fq_rd_q + PTR_W'(1);
        end
        fq_cnt_q <= fq_cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (grant) begin
          trk_mem[trk_wr_q] <= pc_q;
          trk_wr_q          <= trk_wr_q + PTR_W'(1);
        end
        if (rsp_keep) begin
          trk_rd_q <= trk_rd_q + PTR_W'(1);
        end
      end
    end
  end

  // Queue head presented to decode
  assign if_inst_valid      = (fq_cnt_q != '0);
  assign if_pc              = fq_mem[fq_rd_q].pc;
  assign if_inst            = fq_mem[fq_rd_q].inst;
  assign if_inst_addr_misal = fq_mem[fq_rd_q].misal;
  assign if_bus_err         = fq_mem[fq_rd_q].err;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: the bench is the instruction bus slave and keeps a
// queue-level model of the fetch stream that decode should see.
module tb_if_fetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            if_valid = 1'b0;
  logic            wb_exp_int_flag = 1'b0;
  logic [XLEN-1:0] meh_addr = '0;
  logic            id_is_mret_inst = 1'b0;
  logic [XLEN-1:0] mret_addr = '0;
  logic            bj_flag = 1'b0;
  logic [XLEN-1:0] bj_addr = '0;
  logic            pipe_stall = 1'b0;
  logic            ibus_req;
  logic [XLEN-1:0] ibus_addr;
  logic            ibus_gnt = 1'b0;
  logic            ibus_rvalid = 1'b0;
  logic [XLEN-1:0] ibus_rdata = '0;
  logic            ibus_err = 1'b0;
  logic            if_inst_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic            if_inst_addr_misal;
  logic            if_bus_err;

  always #5 clk = ~clk;

  if_fetch_queue #(.XLEN(XLEN), .FQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid),
    .wb_exp_int_flag(wb_exp_int_flag), .meh_addr(meh_addr),
    .id_is_mret_inst(id_is_mret_inst), .mret_addr(mret_addr),
    .bj_flag(bj_flag), .bj_addr(bj_addr), .pipe_stall(pipe_stall),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .ibus_err(ibus_err),
    .if_inst_valid(if_inst_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_inst_addr_misal(if_inst_addr_misal), .if_bus_err(if_bus_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misal;
    logic        err;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } req_t;

  ent_t        exp_q[$];   // entries decode should see, head first
  req_t        pend[$];    // requests the bus slave still owes a response
  int          epoch = 0;
  logic [31:0] m_pc = RPC;
  logic        m_halt = 1'b0;
  logic        want_rsp = 1'b0;
  logic        want_err = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic model_req();
    return !rst && !m_halt && if_valid && (m_pc[1:0] == 2'b00) &&
           ((exp_q.size() + pend.size()) < DEPTH);
  endfunction

  // One clock: drive the bus response, step the model across the edge.
  task automatic advance();
    bit          red, rsp, grant, misal;
    int          cur_pend;
    logic [31:0] tgt;
    req_t        r;
    ent_t        e;
    rsp         = want_rsp && (pend.size() > 0) && !rst;
    ibus_rvalid = rsp;
    ibus_rdata  = rsp ? mem_word(pend[0].addr) : 32'h0;
    ibus_err    = rsp && want_err;
    red   = !rst && (wb_exp_int_flag || id_is_mret_inst || bj_flag);
    tgt   = wb_exp_int_flag ? meh_addr : (id_is_mret_inst ? mret_addr : bj_addr);
    grant = model_req() && ibus_gnt;
    cur_pend = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) cur_pend++;
    misal = !rst && !red && !m_halt && if_valid && (m_pc[1:0] != 2'b00) &&
            (cur_pend == 0) && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      pend.delete();
      epoch++;
      m_pc   = RPC;
      m_halt = 1'b0;
    end else begin
      if (exp_q.size() > 0 && !pipe_stall && !red) void'(exp_q.pop_front());
      if (rsp) begin
        r = pend.pop_front();
        if (r.epoch == epoch && !red) begin
          e = '{pc: r.addr, inst: ibus_rdata, misal: 1'b0, err: ibus_err};
          exp_q.push_back(e);
          if (ibus_err) m_halt = 1'b1;
        end
      end
      if (misal) begin
        e = '{pc: m_pc, inst: 32'h0, misal: 1'b1, err: 1'b0};
        exp_q.push_back(e);
        m_halt = 1'b1;
      end
      if (grant) begin
        r = '{addr: m_pc, epoch: epoch};
        pend.push_back(r);
        m_pc = m_pc + 32'd4;
      end
      if (red) begin
        exp_q.delete();
        epoch++;
        m_pc   = tgt;
        m_halt = 1'b0;
      end
    end
    #1;
    ibus_rvalid     = 1'b0;
    ibus_err        = 1'b0;
    wb_exp_int_flag = 1'b0;
    id_is_mret_inst = 1'b0;
    bj_flag         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ibus_gnt = 1'b0;
    want_rsp = 1'b0;
    advance();
    advance();
    rst = 1'b0;
    if_valid = 1'b1;
    pipe_stall = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_valid = 1'b1; ibus_gnt = 1'b0; want_rsp = 1'b0;
    advance();
    advance();
    n_vec++; if (ibus_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", ibus_req); end
    n_vec++; if (if_inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", if_inst_valid); end
    n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", if_pc); end
    n_vec++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h want 0", if_inst); end
    n_vec++; if (if_inst_addr_misal !== 1'b0) begin n_err++; $display("FAIL reset_misal got %b want 0", if_inst_addr_misal); end
    n_vec++; if (if_bus_err !== 1'b0) begin n_err++; $display("FAIL reset_buserr got %b want 0", if_bus_err); end
    rst = 1'b0;
    #1;
    n_vec++;
    if (ibus_req !== 1'b1 || ibus_addr !== RPC) begin
      n_err++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=%h", ibus_req, ibus_addr, RPC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    ibus_gnt = 1'b1; want_rsp = 1'b1; want_err = 1'b0;
    for (int c = 0; c < 12; c++) begin
      n_vec++;
      if (ibus_req !== 1'b1 || ibus_addr !== 32'(4 * c)) begin
        n_err++; $display("FAIL stream_req c=%0d got req=%b addr=%h want addr=%h", c, ibus_req, ibus_addr, 32'(4 * c));
      end
      if (c >= 2) begin
        n_vec++;
        if (if_inst_valid !== 1'b1 || if_pc !== 32'(4 * (c - 2)) || if_inst !== mem_word(32'(4 * (c - 2)))) begin
          n_err++; $display("FAIL stream_head c=%0d got v=%b pc=%h inst=%h want pc=%h", c, if_inst_valid, if_pc, if_inst, 32'(4 * (c - 2)));
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    int grants;
    bit seen_req;
    do_reset();
    pipe_stall = 1'b1; ibus_gnt = 1'b1; want_rsp = 1'b1;
    grants = 0;
    for (int c = 0; c < 12; c++) begin
      if (ibus_req && ibus_gnt) grants++;
      advance();
    end
    n_vec++; if (grants !== DEPTH) begin n_err++; $display("FAIL stall_grants got %0d want %0d", grants, DEPTH); end
    n_vec++; if (ibus_req !== 1'b0) begin n_err++; $display("FAIL stall_req got %b want 0", ibus_req); end
    pipe_stall = 1'b0;
    seen_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (if_inst_valid !== 1'b1 || if_pc !== 32'(4 * k)) begin
        n_err++; $display("FAIL stall_drain k=%0d got v=%b pc=%h want pc=%h", k, if_inst_valid, if_pc, 32'(4 * k));
      end
      if (ibus_req) seen_req = 1'b1;
      advance();
    end
    n_vec++; if (!seen_req) begin n_err++; $display("FAIL stall_resume got req=0 want req=1"); end
  endtask

  task automatic test_redirect_discard();
    int  t;
    do_reset();
    ibus_gnt = 1'b1; want_rsp = 1'b0;
    advance();
    advance();
    n_vec++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h8) begin
      n_err++; $display("FAIL disc_third got req=%b addr=%h want addr=8", ibus_req, ibus_addr);
    end
    bj_flag = 1'b1; bj_addr = 32'h100;
    advance();
    n_vec++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h100 || if_inst_valid !== 1'b0) begin
      n_err++; $display("FAIL disc_target got req=%b addr=%h v=%b want addr=100 v=0", ibus_req, ibus_addr, if_inst_valid);
    end
    want_rsp = 1'b1;
    t = 0;
    while (!if_inst_valid && t < 20) begin advance(); t++; end
    n_vec++;
    if (t >= 20 || if_pc !== 32'h100) begin
      n_err++; $display("FAIL disc_first_pc got v=%b pc=%h want pc=100", if_inst_valid, if_pc);
    end
  endtask

  task automatic test_priority();
    int t;
    do_reset();
    ibus_gnt = 1'b0; want_rsp = 1'b0;
    wb_exp_int_flag = 1'b1; meh_addr = 32'h80; bj_flag = 1'b1; bj_addr = 32'h200;
    advance();
    n_vec++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h80) begin
      n_err++; $display("FAIL prio_trap got req=%b addr=%h want addr=80", ibus_req, ibus_addr);
    end
    ibus_gnt = 1'b1; want_rsp = 1'b1;
    t = 0;
    while (!if_inst_valid && t < 20) begin advance(); t++; end
    n_vec++;
    if (t >= 20 || if_pc !== 32'h80) begin
      n_err++; $display("FAIL prio_head got v=%b pc=%h want pc=80", if_inst_valid, if_pc);
    end
    id_is_mret_inst = 1'b1; mret_addr = 32'h300; bj_flag = 1'b1; bj_addr = 32'h200;
    ibus_gnt = 1'b0;
    advance();
    n_vec++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h300) begin
      n_err++; $display("FAIL prio_mret got req=%b addr=%h want addr=300", ibus_req, ibus_addr);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    ibus_gnt = 1'b1; want_rsp = 1'b1;
    advance(); advance(); advance();
    bj_flag = 1'b1; bj_addr = 32'h102;
    advance();
    n_vec++; if (ibus_req !== 1'b0) begin n_err++; $display("FAIL misal_noreq got %b want 0", ibus_req); end
    advance();
    pipe_stall = 1'b1;
    n_vec++;
    if (if_inst_valid !== 1'b1 || if_pc !== 32'h102 || if_inst_addr_misal !== 1'b1 ||
        if_inst !== 32'h0 || if_bus_err !== 1'b0) begin
      n_err++; $display("FAIL misal_entry got v=%b pc=%h misal=%b inst=%h err=%b want pc=102 misal=1",
                        if_inst_valid, if_pc, if_inst_addr_misal, if_inst, if_bus_err);
    end
    for (int c = 0; c < 5; c++) begin
      advance();
      n_vec++; if (ibus_req !== 1'b0) begin n_err++; $display("FAIL misal_halt c=%0d got req=%b want 0", c, ibus_req); end
    end
    pipe_stall = 1'b0;
    id_is_mret_inst = 1'b1; mret_addr = 32'h104;
    advance();
    n_vec++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h104) begin
      n_err++; $display("FAIL misal_resume got req=%b addr=%h want addr=104", ibus_req, ibus_addr);
    end
  endtask

  task automatic test_bus_err();
    int t;
    bit found;
    do_reset();
    ibus_gnt = 1'b1; want_rsp = 1'b1;
    found = 1'b0;
    t = 0;
    while (!found && t < 30) begin
      if (if_inst_valid && if_pc == 32'h8) begin
        found = 1'b1;
        n_vec++;
        if (if_bus_err !== 1'b1 || if_inst !== mem_word(32'h8)) begin
          n_err++; $display("FAIL buserr_entry got err=%b inst=%h want err=1 inst=%h", if_bus_err, if_inst, mem_word(32'h8));
        end
      end else begin
        want_err = (pend.size() > 0) && (pend[0].addr == 32'h8);
        advance();
        t++;
      end
    end
    want_err = 1'b0;
    if (!found) begin n_vec++; n_err++; $display("FAIL buserr_timeout got no entry at pc 8 want one"); end
    for (int c = 0; c < 10; c++) advance();
    n_vec++;
    if (ibus_req !== 1'b0 || if_inst_valid !== 1'b0) begin
      n_err++; $display("FAIL buserr_halt got req=%b v=%b want req=0 v=0", ibus_req, if_inst_valid);
    end
    id_is_mret_inst = 1'b1; mret_addr = 32'h40;
    advance();
    n_vec++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h40) begin
      n_err++; $display("FAIL buserr_resume got req=%b addr=%h want addr=40", ibus_req, ibus_addr);
    end
  endtask

  task automatic test_random();
    logic exp_r;
    logic [31:0] a;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c == 750) begin
        rst = 1'b1;
        advance();
        rst = 1'b0;
        #1;
      end
      exp_r = model_req();
      n_vec++;
      if (ibus_req !== exp_r) begin
        n_err++; $display("FAIL rnd_req c=%0d got %b want %b", c, ibus_req, exp_r);
      end
      if (exp_r) begin
        n_vec++;
        if (ibus_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr c=%0d got %h want %h", c, ibus_addr, m_pc); end
      end
      n_vec++;
      if (if_inst_valid !== (exp_q.size() != 0)) begin
        n_err++; $display("FAIL rnd_valid c=%0d got %b want %b", c, if_inst_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        n_vec++;
        if (if_pc !== exp_q[0].pc || if_inst !== exp_q[0].inst ||
            if_inst_addr_misal !== exp_q[0].misal || if_bus_err !== exp_q[0].err) begin
          n_err++; $display("FAIL rnd_head c=%0d got pc=%h inst=%h m=%b e=%b want pc=%h inst=%h m=%b e=%b",
                            c, if_pc, if_inst, if_inst_addr_misal, if_bus_err,
                            exp_q[0].pc, exp_q[0].inst, exp_q[0].misal, exp_q[0].err);
        end
      end
      if_valid   = ($urandom_range(0, 9) != 0);
      pipe_stall = ($urandom_range(0, 3) == 0);
      ibus_gnt   = ($urandom_range(0, 2) != 0);
      want_rsp   = ($urandom_range(0, 2) != 0);
      want_err   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0 || (m_halt && $urandom_range(0, 7) == 0)) begin
        a = $urandom() & 32'h0000_0FFC;
        if ($urandom_range(0, 5) == 0) a = a | 32'(($urandom_range(1, 3)));
        case ($urandom_range(0, 3))
          0: begin wb_exp_int_flag = 1'b1; meh_addr = a; bj_flag = $urandom_range(0, 1) != 0; bj_addr = a + 32'h40; end
          1: begin id_is_mret_inst = 1'b1; mret_addr = a; bj_flag = $urandom_range(0, 1) != 0; bj_addr = a + 32'h80; end
          default: begin bj_flag = 1'b1; bj_addr = a; end
        endcase
      end
      advance();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_discard();
    test_priority();
    test_misaligned();
    test_bus_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter XLEN, default 32: address and instruction width.
REQ-002 Parameter FQ_DEPTH, default 4: fetch-queue entries and outstanding-request limit; power of 2, minimum 2.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 Ports: clk in 1, single clock; all state updates on the rising edge.
REQ-005 Ports: rst in 1, synchronous active-high reset.
REQ-006 Ports: if_valid in 1, fetch enable.
REQ-007 Ports: wb_exp_int_flag in 1 and meh_addr in XLEN, trap redirect.
REQ-008 Ports: id_is_mret_inst in 1 and mret_addr in XLEN, mret redirect.
REQ-009 Ports: bj_flag in 1 and bj_addr in XLEN, branch/jump redirect.
REQ-010 Ports: pipe_stall in 1, decode cannot accept.
REQ-011 Ports: ibus_req out 1, ibus_addr out XLEN, ibus_gnt in 1, request channel.
REQ-012 Ports: ibus_rvalid in 1, ibus_rdata in XLEN, ibus_err in 1, in-order response channel.
REQ-013 Ports: if_inst_valid out 1, if_pc out XLEN, if_inst out XLEN, queue head.
REQ-014 Ports: if_inst_addr_misal out 1 and if_bus_err out 1, head exception flags.

Function
REQ-015 Redirect priority SHALL be: wb_exp_int_flag, then id_is_mret_inst, then bj_flag; the winning target loads fetch PC next cycle.
REQ-016 Fetch FSM states SHALL be RUN and HALT; reset enters RUN with PC=RESET_PC.
REQ-017 In RUN with if_valid=1, aligned PC and (queue count + outstanding) < FQ_DEPTH, ibus_req SHALL be 1 with ibus_addr=PC.
REQ-018 A request is accepted on ibus_req&ibus_gnt; PC SHALL then advance by 4 (mod 2^XLEN) and outstanding SHALL increment.
REQ-019 While ibus_req=1 without gnt, ibus_addr SHALL stay stable unless a redirect occurs, which may abandon the ungranted request.
REQ-020 Each request's PC SHALL be tracked in issue order; each ibus_rvalid SHALL pair with the oldest outstanding PC.
REQ-021 Responses SHALL be written to the queue and become visible on if_inst_valid the cycle after ibus_rvalid, with no bypass.
REQ-022 The head pops when if_inst_valid=1 and pipe_stall=0.
REQ-023 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-024 By construction the queue never overflows; a response arriving while the queue is full with discard count 0 is a protocol error.
REQ-025 On a redirect the queue SHALL be flushed and if_inst_valid forced to 0 the next cycle.
REQ-026 On a redirect, discard_cnt SHALL be set to all still-unreturned outstanding requests, including a request granted and excluding a response returned in that same cycle.
REQ-027 While discard_cnt>0, each rvalid SHALL be dropped and decrement discard_cnt.
REQ-028 New requests MAY issue during discard, subject to REQ-017 with discards counted as outstanding.
REQ-029 When PC[1:0]!=0 in RUN with if_valid=1, the block SHALL not request and SHALL push one entry {pc, inst=0, misal=1}, then enter HALT.
REQ-030 A response with ibus_err=1 SHALL push {pc, rdata, err=1} and enter HALT; already-granted requests still return and are queued.
REQ-031 HALT SHALL issue no requests and leaves only on a redirect, returning to RUN.
REQ-032 A pop concurrent with a redirect SHALL be ignored.
REQ-033 if_valid=0 SHALL block new requests only; outstanding responses still complete.

Reset
REQ-034 Reset SHALL clear the queue, outstanding count and discard_cnt, set PC=RESET_PC and state RUN.
REQ-035 Reset values: ibus_req=0, if_inst_valid=0, if_pc=0, if_inst=0, if_inst_addr_misal=0, if_bus_err=0.
REQ-036 Reset asserted mid-transfer SHALL drop all in-flight state; the bench holds ibus_rvalid low until the first post-reset grant.
REQ-037 The first request SHALL appear the cycle after rst deasserts.

Verification
REQ-038 Reset release, gnt=1 always, rvalid one cycle after gnt, no stall -> requests 0x0,0x4,0x8..., if_pc=0x0 valid 3 cycles after rst low, one instruction per cycle thereafter.
REQ-039 Depth 4, pipe_stall=1 held -> exactly 4 grants, then ibus_req=0; release stall -> one pop per cycle and requests resume.
REQ-040 Two outstanding requests, bj_flag with bj_addr=0x100 in the cycle of a third grant -> 3 responses dropped; next visible if_pc=0x100.
REQ-041 wb_exp_int_flag (meh_addr=0x80) and bj_flag (0x200) in the same cycle -> fetch resumes at 0x80.
REQ-042 bj_addr=0x102 -> no bus request, one entry if_pc=0x102 with if_inst_addr_misal=1, HALT until mret_addr=0x104 redirect.
REQ-043 ibus_err on the response for 0x8 -> entry 0x8 with if_bus_err=1, no further requests until redirect.
